spi_slave_ram: RTL

- SPI slave endpoint that sits directly downstream of the team's SPI master, on its CSN/SCLK/MOSI/MISO pins.
- Decodes the 2-bit command and the address, then does one of two things:
  - write: captures the data bits into an internal register-file RAM;
  - read: serialises the addressed word back on MISO.
- Runs entirely in the CLK domain and oversamples the SPI pins.
- Frame format (MSB first, mode 0, SCLK idle low): {CMD[1:0], ADDR[ADDR_BIT-1:0], DATA[DATA_BIT-1:0]}.

---
 rtl/spi_slave_ram.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_ram.sv
// -----------------------------------------------------------------------------
// spi_slave_ram
//   SPI mode-0 slave endpoint with an internal register-file RAM. The SPI pins
//   are oversampled in the CLK domain. Frame format, MSB first:
//   {CMD[1:0], ADDR[ADDR_BIT-1:0], DATA[DATA_BIT-1:0]}
//     CMD=10 : write DATA into RAM[ADDR]
//     CMD=01 : read RAM[ADDR] back on MISO during the data phase
//     CMD=00/11 : invalid, flagged on CMD_ERR, rest of frame ignored
//
//   Handshake/strobe semantics: WR_STB, RD_STB and CMD_ERR are single-CLK,
//   registered pulses with no back-pressure. WR_STB is high on the same CLK
//   in which the RAM word is written, so DBG_DATA shows the new word one CLK
//   after WR_STB.
//
// Ports
//   CLK      in   system clock, rising edge
//   RST      in   synchronous active-high reset (also clears the RAM)
//   CSN      in   chip select, active low, asynchronous
//   SCLK     in   SPI clock, asynchronous, idle low
//   MOSI     in   serial data in
//   MISO     out  serial read data (0 outside READ / WAIT_CS-after-read)
//   WR_STB   out  RAM write commit pulse
//   RD_STB   out  read frame completion pulse
//   CMD_ERR  out  invalid command pulse
//   DBG_ADDR in   backdoor read address
//   DBG_DATA out  combinational RAM[DBG_ADDR]
// -----------------------------------------------------------------------------
module spi_slave_ram #(
    parameter int DATA_BIT = 4,
    parameter int ADDR_BIT = 3,
    parameter int SPI_BIT  = 2 + ADDR_BIT + DATA_BIT
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                CSN,
    input  logic                SCLK,
    input  logic                MOSI,
    output logic                MISO,
    output logic                WR_STB,
    output logic                RD_STB,
    output logic                CMD_ERR,
    input  logic [ADDR_BIT-1:0] DBG_ADDR,
    output logic [DATA_BIT-1:0] DBG_DATA
);

    localparam int HDR_BIT = 2 + ADDR_BIT;
    localparam int DEPTH   = 2 ** ADDR_BIT;
    localparam int CW      = $clog2(SPI_BIT + 1);
    localparam logic [CW-1:0] HDR_LAST  = CW'(HDR_BIT - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BIT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR     = 3'd1,
        WRITE   = 3'd2,
        READ    = 3'd3,
        WAIT_CS = 3'd4
    } state_t;

    // Pin synchronisers; the third SCLK flop is only for edge detection.
    logic csn_s1, csn_s2;
    logic sclk_s1, sclk_s2, sclk_s3;
    logic mosi_s1, mosi_s2;
    logic sclk_rise, sclk_fall;

    always_ff @(posedge CLK) begin
        if (RST) begin
            csn_s1  <= 1'b1;
            csn_s2  <= 1'b1;
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_s3 <= 1'b0;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            csn_s1  <= CSN;
            csn_s2  <= csn_s1;
            sclk_s1 <= SCLK;
            sclk_s2 <= sclk_s1;
            sclk_s3 <= sclk_s2;
            mosi_s1 <= MOSI;
            mosi_s2 <= mosi_s1;
        end
    end

    assign sclk_rise = sclk_s2 & ~sclk_s3;
    assign sclk_fall = ~sclk_s2 & sclk_s3;

    // Frame state. hdr keeps the address after decode; dsr is the write
    // capture register in WRITE and the read-out shift register in READ.
    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [HDR_BIT-1:0]   hdr, hdr_n, hdr_shift;
    logic [DATA_BIT-1:0]  dsr, dsr_n, data_shift;
    logic                 miso, miso_n;
    logic                 wr_stb, wr_n;
    logic                 rd_stb, rd_n;
    logic                 cmd_err, err_n;
    logic [DATA_BIT-1:0]  ram [DEPTH];

    assign hdr_shift  = {hdr[HDR_BIT-2:0], mosi_s2};
    assign data_shift = {dsr[DATA_BIT-2:0], mosi_s2};

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        hdr_n   = hdr;
        dsr_n   = dsr;
        miso_n  = miso;
        wr_n    = 1'b0;
        rd_n    = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                cnt_n  = '0;
                miso_n = 1'b0;
                if (!csn_s2) state_n = HDR;
            end
            HDR: begin
                if (csn_s2) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    miso_n  = 1'b0;
                end else if (sclk_rise) begin
                    hdr_n = hdr_shift;
                    cnt_n = cnt + CW'(1);
                    // Decode on the same cycle as the last header bit arrives.
                    if (cnt == HDR_LAST) begin
                        cnt_n = '0;
                        case (hdr_shift[HDR_BIT-1 -: 2])
                            2'b10: state_n = WRITE;
                            2'b01: begin
                                state_n = READ;
                                dsr_n   = ram[hdr_shift[ADDR_BIT-1:0]];
                            end
                            default: begin
                                err_n   = 1'b1;
                                state_n = WAIT_CS;
                            end
                        endcase
                    end
                end
            end
            WRITE: begin
                if (csn_s2) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    miso_n  = 1'b0;
                end else if (sclk_rise) begin
                    dsr_n = data_shift;
                    cnt_n = cnt + CW'(1);
                    if (cnt == DATA_LAST) begin
                        // Commit happens next CLK, while WR_STB is high.
                        wr_n    = 1'b1;
                        state_n = WAIT_CS;
                    end
                end
            end
            READ: begin
                if (csn_s2) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    miso_n  = 1'b0;
                end else begin
                    // Present next bit on each fall so it is stable at the
                    // master's following rise.
                    if (sclk_fall) begin
                        miso_n = dsr[DATA_BIT-1];
                        dsr_n  = {dsr[DATA_BIT-2:0], 1'b0};
                    end
                    if (sclk_rise) begin
                        cnt_n = cnt + CW'(1);
                        if (cnt == DATA_LAST) begin
                            rd_n    = 1'b1;
                            state_n = WAIT_CS;
                        end
                    end
                end
            end
            WAIT_CS: begin
                // MISO keeps the last read bit until chip select drops.
                if (csn_s2) begin
                    state_n = IDLE;
                    miso_n  = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                miso_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            cnt     <= '0;
            hdr     <= '0;
            dsr     <= '0;
            miso    <= 1'b0;
            wr_stb  <= 1'b0;
            rd_stb  <= 1'b0;
            cmd_err <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            hdr     <= hdr_n;
            dsr     <= dsr_n;
            miso    <= miso_n;
            wr_stb  <= wr_n;
            rd_stb  <= rd_n;
            cmd_err <= err_n;
        end
    end

    // hdr and dsr are frozen in WAIT_CS, so they still hold address/data here.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
        end else if (wr_stb) begin
            ram[hdr[ADDR_BIT-1:0]] <= dsr;
        end
    end

    assign MISO     = miso;
    assign WR_STB   = wr_stb;
    assign RD_STB   = rd_stb;
    assign CMD_ERR  = cmd_err;
    assign DBG_DATA = ram[DBG_ADDR];

endmodule
